ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction fetch unit with a decoupled prefetch queue. It owns the fetch PC and issues word-aligned requests to instruction memory over a valid/ready handshake, accepting variable-latency, in-order responses. It buffers up to DEPTH instructions, each tagged with its PC and link address, for the decode stage. A single redirect input covers branch, jump, jal and jr targets; on redirect, buffered and in-flight instructions are flushed.

## Interface
- ADDR_W, 32, PC/address width in bits
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 0, fetch address after reset (byte address, word-aligned)
- CNT_W, 32, performance counter width
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  byte address of the requested word; bits [1:0] always 0
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  instruction word returned; responses arrive in request order
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  core redirects fetch (taken beq/bne, j, jal, jr)
- redirect_addr  in  ADDR_W  byte target address; bits [1:0] ignored
- inst_valid  out  1  queue head valid
- inst_data  out  32  head instruction
- inst_pc  out  ADDR_W  head PC
- inst_link_addr  out  ADDR_W  head PC + 4, used by jal
- inst_ready  in  1  decode consumes head
- perf_fetched  out  CNT_W  instructions delivered
- perf_flushed  out  CNT_W  instructions discarded by redirect

## Operation
- State:
  - fpc: next fetch address.
  - Queue of DEPTH entries {data, pc}.
  - Tag FIFO of PCs for outstanding requests.
  - outstanding: 0..DEPTH.
  - drop: 0..outstanding; count of responses to discard.
- Issue condition: imem_req_valid = !redirect_valid && (count + outstanding − drop) < DEPTH && outstanding < DEPTH.
- imem_req_addr = fpc.
- Request handshake (valid && ready):
  - Push fpc into the tag FIFO.
  - outstanding +1.
  - fpc += 4, wrapping modulo 2^ADDR_W.
- Response, drop = 0:
  - Pop the tag FIFO.
  - Push {imem_rsp_data, tag} into the queue.
  - outstanding −1.
- Response, drop > 0: discard, drop −1, outstanding −1, pop the tag FIFO.
- Pop: when inst_valid && inst_ready.
- inst_link_addr = inst_pc + 4, wrapping.
- Redirect, highest priority:
  - Queue emptied.
  - fpc ← redirect_addr with bits [1:0] = 0.
  - drop ← outstanding − (imem_rsp_valid ? 1 : 0); a response in the redirect cycle is discarded and not queued.
  - A pop in the redirect cycle is ignored and not counted as fetched.
  - No request is issued in the redirect cycle.
  - Redirect during an existing drop: drop is recomputed by the same rule.
- Full queue: credit rule guarantees a response always has space. A response with a full queue is an assertion failure.
- Empty queue: inst_valid = 0; inst_data, inst_pc and inst_link_addr hold their last values.
- Reset, any cycle including mid-burst:
  - fpc = RESET_PC.
  - Queue and tag FIFO empty; outstanding = drop = 0.
  - inst_valid = 0, imem_req_valid = 0.
  - inst_data/inst_pc/inst_link_addr = 0; counters = 0.
  - Responses during reset are ignored.
  - The memory must be reset together with this block.

## Timing
- imem_req_valid and imem_req_addr are combinational from registered state and redirect_valid.
- inst_* outputs are combinational from queue state, with no input-to-output path.
- Response to inst_valid: a response in cycle N gives inst_valid in cycle N+1.
- Redirect to first new instruction, 1-cycle memory:
  - Redirect in cycle N, request in N+1, response in N+2, inst_valid with inst_pc = target in N+3.
- Sustained throughput is 1 instruction/cycle when DEPTH ≥ memory latency + 1 and inst_ready stays high.
- Queue push and pop in the same cycle are both honoured; count is unchanged.

## Configuration
- IFETCH_PERF_COUNT_EN defined:
  - perf_fetched +1 per pop.
  - perf_flushed + (queue count at redirect) + 1 per discarded response.
  - Both wrap at 2^CNT_W.
- Undefined: no counter registers are built; perf_fetched and perf_flushed are constant 0.

## Test plan
- Reset, 1-cycle memory, inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8…; inst_link_addr 0x4, 0x8, 0xC…; one instruction/cycle after a 2-cycle fill.
- inst_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0. Release -> PCs 0x0–0xC delivered in order, fetch resumes at 0x10.
- 3-cycle memory latency, 2 requests in flight, redirect_addr = 0x103 -> both stale responses discarded; next request is 0x100; first inst_pc = 0x100. perf_flushed increases by queue count + 2.
- Redirect coinciding with imem_rsp_valid and an inst_ready pop -> response not queued, pop not counted; inst_valid = 0 next cycle; fpc = target.
- imem_req_ready toggling pseudo-randomly over 200 instructions -> no PC skipped or duplicated; inst_data matches the memory model at inst_pc. perf_fetched = 200 when IFETCH_PERF_COUNT_EN is defined, 0 otherwise.
- Reset asserted mid-burst with 3 outstanding -> next cycle inst_valid = 0, imem_req_valid = 0; first post-reset request at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with a decoupled prefetch queue.
// Owns the fetch PC, issues word-aligned requests to instruction memory and
// buffers up to DEPTH returned instructions, each tagged with its PC, for decode.
// Optional build macro: IFETCH_PERF_COUNT_EN enables the perf_fetched /
// perf_flushed counters; without it both outputs are tied to zero.
//
// Handshakes: a transfer happens on a rising clock edge when both valid and
// ready are high in that cycle. valid never depends on ready of the same port.
// Memory responses carry no ready: they are accepted unconditionally, so the
// request side only issues when a queue slot is guaranteed for the response.
module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_link_addr,
  input  logic              inst_ready,
  output logic [CNT_W-1:0]  perf_fetched,
  output logic [CNT_W-1:0]  perf_flushed
);

  localparam int            PTR_W   = $clog2(DEPTH);
  localparam int            CW      = PTR_W + 1;
  localparam logic [CW:0]   DEPTH_E = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Fetch PC and request bookkeeping
  logic [ADDR_W-1:0] fpc_q;
  logic [ADDR_W-1:0] tag_pc [DEPTH];
  logic [PTR_W-1:0]  tag_rd, tag_wr;
  logic [CW-1:0]     outst_q;
  logic [CW-1:0]     drop_q;

  // Instruction queue
  logic [31:0]       q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  q_rd, q_wr;
  logic [CW-1:0]     q_cnt;

  // Last presented head, shown while the queue is empty
  logic [31:0]       hold_data;
  logic [ADDR_W-1:0] hold_pc;
  logic [ADDR_W-1:0] hold_link;

  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              pop;
  logic [ADDR_W-1:0] head_pc;
  logic              unused_addr_bits;

  // Slots already promised: queued entries plus responses still to be kept.
  assign credit_used    = {1'b0, q_cnt} + {1'b0, outst_q} - {1'b0, drop_q};
  assign imem_req_valid = !reset && !redirect_valid &&
                          (credit_used < DEPTH_E) && (outst_q < DEPTH_C);
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle belongs to the old stream and is discarded.
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_q != '0);
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  assign head_pc        = q_pc[q_rd];
  assign inst_valid     = (q_cnt != '0);
  assign inst_data      = inst_valid ? q_data[q_rd] : hold_data;
  assign inst_pc        = inst_valid ? head_pc : hold_pc;
  assign inst_link_addr = inst_valid ? head_pc + ADDR_W'(4) : hold_link;

  assign unused_addr_bits = ^redirect_addr[1:0];

  // Fetch PC, tag pointers, outstanding and drop accounting
  always_ff @(posedge clock) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      tag_rd  <= '0;
      tag_wr  <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      if (redirect_valid) begin
        fpc_q <= {redirect_addr[ADDR_W-1:2], 2'b00};
      end else if (req_fire) begin
        fpc_q <= fpc_q + ADDR_W'(4);
      end
      if (req_fire) begin
        tag_wr <= tag_wr + PTR_W'(1);
      end
      if (imem_rsp_valid) begin
        tag_rd <= tag_rd + PTR_W'(1);
      end
      case ({req_fire, imem_rsp_valid})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
      // Every request still in flight after this cycle belongs to the old stream.
      if (redirect_valid) begin
        drop_q <= outst_q - CW'(imem_rsp_valid);
      end else if (rsp_drop) begin
        drop_q <= drop_q - CW'(1);
      end
    end
  end

  // Tag and queue storage (no reset needed, validity lives in the pointers)
  always_ff @(posedge clock) begin
    if (req_fire) begin
      tag_pc[tag_wr] <= fpc_q;
    end
    if (rsp_keep && !reset) begin
      q_data[q_wr] <= imem_rsp_data;
      q_pc[q_wr]   <= tag_pc[tag_rd];
    end
  end

  // Queue pointers and occupancy; redirect empties the queue
  always_ff @(posedge clock) begin
    if (reset || redirect_valid) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (rsp_keep) begin
        q_wr <= q_wr + PTR_W'(1);
      end
      if (pop) begin
        q_rd <= q_rd + PTR_W'(1);
      end
      case ({rsp_keep, pop})
        2'b10:   q_cnt <= q_cnt + CW'(1);
        2'b01:   q_cnt <= q_cnt - CW'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Track the head being presented so the outputs hold once the queue drains
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_data <= '0;
      hold_pc   <= '0;
      hold_link <= '0;
    end else if (inst_valid) begin
      hold_data <= q_data[q_rd];
      hold_pc   <= head_pc;
      hold_link <= head_pc + ADDR_W'(4);
    end
  end

  // Credit rule means a kept response always finds room and has a request behind it
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(rsp_keep && (q_cnt == DEPTH_C)));
      assert (!(imem_rsp_valid && (outst_q == '0)));
    end
  end

`ifdef IFETCH_PERF_COUNT_EN
  logic [CNT_W-1:0] fetched_q;
  logic [CNT_W-1:0] flushed_q;

  // Delivered and discarded instruction counters, wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (pop) begin
        fetched_q <= fetched_q + CNT_W'(1);
      end
      if (redirect_valid) begin
        flushed_q <= flushed_q + CNT_W'(q_cnt) + CNT_W'(imem_rsp_valid);
      end else if (rsp_drop) begin
        flushed_q <= flushed_q + CNT_W'(1);
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`else
  assign perf_fetched = '0;
  assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order variable-latency memory model, expected-PC
// scoreboard filled on each accepted request and drained on each delivery.
`timescale 1ns/1ps
module tb_ifetch_queue;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          CNT_W    = 32;
`ifdef IFETCH_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] inst_link_addr;
  logic              inst_ready;
  logic [CNT_W-1:0]  perf_fetched;
  logic [CNT_W-1:0]  perf_flushed;

  ifetch_queue #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_link_addr(inst_link_addr),
    .inst_ready    (inst_ready),
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due;
  logic [31:0] exp_fpc;
  int          exp_fetched;
  int          n_fire;

  logic        drv_reset, drv_redirect, drv_inst_ready, drv_req_ready;
  logic [31:0] drv_raddr;
  int          lat_min, lat_max;

  logic        obs_inst_valid, obs_req_valid, obs_fire;
  logic [31:0] obs_inst_pc, obs_inst_data, obs_link, obs_fire_addr;
  logic [31:0] obs_fetched, obs_flushed;

  // Memory contents as a function of the word address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[17:2] ^ 16'hC3A5, a[17:2]};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [31:0] pc;
    int          due;
    @(negedge clock);
    reset          = drv_reset;
    redirect_valid = drv_redirect;
    redirect_addr  = drv_raddr;
    inst_ready     = drv_inst_ready;
    imem_req_ready = drv_req_ready;
    if (drv_reset) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_q.delete();
      last_due       = 0;
      exp_fpc        = RESET_PC;
      exp_fetched    = 0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
    end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(mem_addr_q[0]);
      void'(mem_due_q.pop_front());
      void'(mem_addr_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    obs_inst_valid = inst_valid;
    obs_req_valid  = imem_req_valid;
    obs_inst_pc    = inst_pc;
    obs_inst_data  = inst_data;
    obs_link       = inst_link_addr;
    obs_fetched    = perf_fetched;
    obs_flushed    = perf_flushed;
    obs_fire       = imem_req_valid && imem_req_ready;
    obs_fire_addr  = imem_req_addr;
    if (!drv_reset) begin
      if (drv_redirect) begin
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL redirect_no_req: got %b, expected 0", imem_req_valid);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (imem_req_addr !== exp_fpc) begin
          n_bad++;
          $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_fpc);
        end
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(due);
        exp_q.push_back(exp_fpc);
        exp_fpc = exp_fpc + 32'd4;
        n_fire++;
      end
      if (inst_valid && inst_ready && !drv_redirect) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
        end else begin
          pc = exp_q.pop_front();
          if (inst_pc !== pc || inst_link_addr !== pc + 32'd4 || inst_data !== mem_f(pc)) begin
            n_bad++;
            $display("FAIL inst: got pc %h link %h data %h, expected pc %h link %h data %h",
                     inst_pc, inst_link_addr, inst_data, pc, pc + 32'd4, mem_f(pc));
          end
          exp_fetched++;
        end
      end
      if (drv_redirect) begin
        exp_q.delete();
        exp_fpc = {drv_raddr[31:2], 2'b00};
      end
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic apply_reset();
    drv_reset    = 1'b1;
    drv_redirect = 1'b0;
    step();
    step();
    drv_reset = 1'b0;
    n_fire    = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drv_inst_ready = 1'b1;
    drv_req_ready  = 1'b1;
    lat_min = 1;
    lat_max = 1;
    apply_reset();
    n_cmp++;
    if (obs_inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b, expected 0", obs_inst_valid); end
    n_cmp++;
    if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b, expected 0", obs_req_valid); end
    n_cmp++;
    if (obs_inst_data !== 32'h0) begin n_bad++; $display("FAIL reset_inst_data: got %h, expected 0", obs_inst_data); end
    n_cmp++;
    if (obs_inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h, expected 0", obs_inst_pc); end
    n_cmp++;
    if (obs_link !== 32'h0) begin n_bad++; $display("FAIL reset_link: got %h, expected 0", obs_link); end
    n_cmp++;
    if (obs_fetched !== 32'h0 || obs_flushed !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_perf: got %h/%h, expected 0/0", obs_fetched, obs_flushed);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      step();
      n_cmp++;
      if (obs_inst_valid !== (k >= 2)) begin
        n_bad++;
        $display("FAIL stream_valid[%0d]: got %b, expected %b", k, obs_inst_valid, (k >= 2));
      end
      if (k >= 2) begin
        n_cmp++;
        if (obs_inst_pc !== 32'(4 * (k - 2))) begin
          n_bad++;
          $display("FAIL stream_pc[%0d]: got %h, expected %h", k, obs_inst_pc, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    apply_reset();
    drv_inst_ready = 1'b0;
    drv_req_ready  = 1'b1;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (n_fire !== 4) begin n_bad++; $display("FAIL bp_requests: got %0d, expected 4", n_fire); end
    n_cmp++;
    if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b, expected 0", obs_req_valid); end
    drv_inst_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (obs_fire) begin
        seen = 1'b1;
        n_cmp++;
        if (obs_fire_addr !== 32'h10) begin
          n_bad++;
          $display("FAIL bp_resume_addr: got %h, expected 00000010", obs_fire_addr);
        end
      end
    end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL bp_resume: got no request, expected request"); end
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (exp_fetched < 4) begin n_bad++; $display("FAIL bp_delivered: got %0d, expected >= 4", exp_fetched); end
  endtask

  task automatic test_redirect_flush();
    logic [31:0] base;
    apply_reset();
    lat_min = 3;
    lat_max = 3;
    drv_inst_ready = 1'b0;
    drv_req_ready  = 1'b1;
    step();
    step();
    drv_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    drv_req_ready = 1'b1;
    step();
    step();
    // queue holds 0x0/0x4, 0x8/0xC in flight
    drv_redirect = 1'b1;
    drv_raddr    = 32'h103;
    step();
    base         = obs_flushed;
    drv_redirect = 1'b0;
    drv_inst_ready = 1'b1;
    step();
    n_cmp++;
    if (obs_fire !== 1'b1 || obs_fire_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL flush_first_req: got %b/%h, expected 1/00000100", obs_fire, obs_fire_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (obs_inst_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale[%0d]: got %b, expected 0", k, obs_inst_valid); end
    end
    step();
    n_cmp++;
    if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL flush_first_pc: got %b/%h, expected 1/00000100", obs_inst_valid, obs_inst_pc);
    end
    drv_req_ready = 1'b0;
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (obs_flushed !== (PERF ? base + 32'd4 : 32'd0)) begin
      n_bad++;
      $display("FAIL flush_perf: got %h, expected %h", obs_flushed, (PERF ? base + 32'd4 : 32'd0));
    end
  endtask

  task automatic test_redirect_collide();
    apply_reset();
    lat_min = 1;
    lat_max = 1;
    drv_inst_ready = 1'b1;
    drv_req_ready  = 1'b1;
    for (int k = 0; k < 6; k++) step();
    drv_redirect = 1'b1;
    drv_raddr    = 32'h200;
    step();
    n_cmp++;
    if (obs_inst_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_setup: got inst_valid %b rsp %b, expected 1/1", obs_inst_valid, imem_rsp_valid);
    end
    drv_redirect = 1'b0;
    step();
    n_cmp++;
    if (obs_inst_valid !== 1'b0) begin n_bad++; $display("FAIL collide_n1_valid: got %b, expected 0", obs_inst_valid); end
    n_cmp++;
    if (obs_fire !== 1'b1 || obs_fire_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL collide_req: got %b/%h, expected 1/00000200", obs_fire, obs_fire_addr);
    end
    step();
    n_cmp++;
    if (obs_inst_valid !== 1'b0) begin n_bad++; $display("FAIL collide_n2_valid: got %b, expected 0", obs_inst_valid); end
    step();
    n_cmp++;
    if (obs_inst_valid !== 1'b1 || obs_inst_pc !== 32'h200) begin
      n_bad++;
      $display("FAIL collide_n3: got %b/%h, expected 1/00000200", obs_inst_valid, obs_inst_pc);
    end
    drv_inst_ready = 1'b0;
    step();
    n_cmp++;
    if (obs_fetched !== (PERF ? 32'(exp_fetched) : 32'd0)) begin
      n_bad++;
      $display("FAIL collide_perf: got %0d, expected %0d", obs_fetched, (PERF ? exp_fetched : 0));
    end
  endtask

  task automatic test_random();
    int k;
    apply_reset();
    lat_min = 1;
    lat_max = 3;
    k = 0;
    while (exp_fetched < 200 && k < 6000) begin
      drv_req_ready  = 1'($urandom_range(0, 1));
      drv_inst_ready = ($urandom_range(0, 3) != 0);
      step();
      k++;
    end
    n_cmp++;
    if (exp_fetched < 200) begin n_bad++; $display("FAIL random_timeout: got %0d, expected 200", exp_fetched); end
    drv_inst_ready = 1'b0;
    drv_req_ready  = 1'b0;
    step();
    step();
    n_cmp++;
    if (obs_fetched !== (PERF ? 32'd200 : 32'd0)) begin
      n_bad++;
      $display("FAIL random_perf: got %0d, expected %0d", obs_fetched, (PERF ? 200 : 0));
    end
  endtask

  task automatic test_reset_midburst();
    bit seen;
    apply_reset();
    lat_min = 3;
    lat_max = 3;
    drv_inst_ready = 1'b0;
    drv_req_ready  = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (n_fire !== 3) begin n_bad++; $display("FAIL mid_setup: got %0d, expected 3", n_fire); end
    drv_reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (obs_inst_valid !== 1'b0 || obs_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b/%b, expected 0/0", obs_inst_valid, obs_req_valid);
    end
    drv_reset = 1'b0;
    step();
    n_cmp++;
    if (obs_fire !== 1'b1 || obs_fire_addr !== RESET_PC) begin
      n_bad++;
      $display("FAIL mid_first_req: got %b/%h, expected 1/%h", obs_fire, obs_fire_addr, RESET_PC);
    end
    drv_inst_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (obs_inst_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (obs_inst_pc !== RESET_PC) begin
          n_bad++;
          $display("FAIL mid_first_pc: got %h, expected %h", obs_inst_pc, RESET_PC);
        end
      end
    end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL mid_no_inst: got none, expected instruction"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    drv_reset      = 1'b1;
    drv_redirect   = 1'b0;
    drv_raddr      = '0;
    drv_inst_ready = 1'b0;
    drv_req_ready  = 1'b0;
    lat_min        = 1;
    lat_max        = 1;
    last_due       = 0;
    exp_fpc        = RESET_PC;
    exp_fetched    = 0;
    n_fire         = 0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_random();
    test_reset_midburst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
